// File: rtl/demultiplexer_3ch_if.sv
// demultiplexer_3ch_if: producer port (data_in/sel/in_valid/in_ready), three channel drains (data/valid/ready), sel_err pulse and err_count
interface demultiplexer_3ch_if #(parameter int word_size = 8);
  logic [word_size-1:0] data_in;
  logic [1:0] sel;
  logic in_valid;
  logic in_ready;
  logic [word_size-1:0] data_a, data_b, data_c;
  logic valid_a, valid_b, valid_c;
  logic ready_a, ready_b, ready_c;
  logic sel_err;
  logic [7:0] err_count;
  modport master (
    output data_in, sel, in_valid, ready_a, ready_b, ready_c,
    input in_ready, data_a, data_b, data_c, valid_a, valid_b, valid_c, sel_err, err_count
  );
  modport slave (
    input data_in, sel, in_valid, ready_a, ready_b, ready_c,
    output in_ready, data_a, data_b, data_c, valid_a, valid_b, valid_c, sel_err, err_count
  );
endinterface

// File: rtl/demultiplexer_3ch.sv
// demultiplexer_3ch: registered 1-to-3 word router; clk/rst plus bus (slave) carrying input handshake, channels a/b/c with valid/ready, illegal-sel pulse and saturating drop count
module demultiplexer_3ch #(
  parameter int word_size = 8
) (
  input logic clk,
  input logic rst,
  demultiplexer_3ch_if.slave bus
);
  logic [word_size-1:0] data [3];
  logic [2:0] valid;
  logic [3:0] full, take;
  logic illegal, accept, sel_err;
  logic [7:0] err_count;
  assign full = {1'b0, valid};
  assign take = {1'b0, bus.ready_c, bus.ready_b, bus.ready_a};
  always_comb begin
    illegal = bus.sel == 2'b11;
    bus.in_ready = illegal | !full[bus.sel] | take[bus.sel];
    accept = bus.in_valid & bus.in_ready;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      data <= '{default: '0};
      sel_err <= 1'b0;
      err_count <= 8'd0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (accept && bus.sel == 2'(i)) begin
          data[i] <= bus.data_in;
          valid[i] <= 1'b1;
        end else if (valid[i] && take[i]) valid[i] <= 1'b0;
      end
      sel_err <= accept & illegal;
      if (accept && illegal && err_count != 8'hff) err_count <= err_count + 8'd1;
    end
  end
  assign bus.data_a = data[0];
  assign bus.data_b = data[1];
  assign bus.data_c = data[2];
  assign bus.valid_a = valid[0];
  assign bus.valid_b = valid[1];
  assign bus.valid_c = valid[2];
  assign bus.sel_err = sel_err;
  assign bus.err_count = err_count;
endmodule

// File: tb/tb_demultiplexer_3ch.sv
// tb_demultiplexer_3ch: directed plan plus random traffic checked against per-channel expected-word queues
module tb_demultiplexer_3ch;
  logic clk = 0;
  logic rst = 1;
  int checks = 0;
  int errors = 0;
  logic [7:0] q [3][$];
  logic exp_se = 0;
  logic [7:0] exp_ec = 0;
  logic held;
  demultiplexer_3ch_if #(.word_size(8)) bus ();
  demultiplexer_3ch #(.word_size(8)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    logic [7:0] d [3];
    logic [2:0] v, r;
    logic rdy;
    d[0] = bus.data_a; d[1] = bus.data_b; d[2] = bus.data_c;
    v = {bus.valid_c, bus.valid_b, bus.valid_a};
    r = {bus.ready_c, bus.ready_b, bus.ready_a};
    if (rst) begin
      for (int c = 0; c < 3; c++) q[c].delete();
      exp_se = 0;
      exp_ec = 0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        check($sformatf("sb_valid%0d", c), 32'(v[c]), 32'(q[c].size() != 0));
        if (q[c].size() != 0) check($sformatf("sb_data%0d", c), 32'(d[c]), 32'(q[c][0]));
      end
      check("sb_sel_err", 32'(bus.sel_err), 32'(exp_se));
      check("sb_err_count", 32'(bus.err_count), 32'(exp_ec));
      rdy = bus.sel == 2'b11 ? 1'b1 : (q[bus.sel].size() == 0 || r[bus.sel]);
      check("sb_in_ready", 32'(bus.in_ready), 32'(rdy));
      for (int c = 0; c < 3; c++) if (q[c].size() != 0 && r[c]) void'(q[c].pop_front());
      exp_se = bus.in_valid && rdy && bus.sel == 2'b11;
      if (exp_se && exp_ec != 8'hff) exp_ec = exp_ec + 8'd1;
      if (bus.in_valid && rdy && bus.sel != 2'b11) q[bus.sel].push_back(bus.data_in);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] w, input logic [1:0] s);
    bus.in_valid = 1; bus.data_in = w; bus.sel = s;
    tick();
    bus.in_valid = 0;
  endtask
  initial begin
    bus.in_valid = 0; bus.data_in = 0; bus.sel = 0;
    bus.ready_a = 0; bus.ready_b = 0; bus.ready_c = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    check("rst_valid", 32'({bus.valid_a, bus.valid_b, bus.valid_c}), 0);
    check("rst_data_a", 32'(bus.data_a), 0);
    check("rst_data_b", 32'(bus.data_b), 0);
    check("rst_data_c", 32'(bus.data_c), 0);
    check("rst_sel_err", 32'(bus.sel_err), 0);
    check("rst_err_count", 32'(bus.err_count), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    send(8'hFC, 2'b00);
    send(8'hFD, 2'b01);
    send(8'hFE, 2'b10);
    check("route_a", 32'(bus.data_a), 32'h FC);
    check("route_b", 32'(bus.data_b), 32'h FD);
    check("route_c", 32'(bus.data_c), 32'h FE);
    check("route_valid", 32'({bus.valid_a, bus.valid_b, bus.valid_c}), 32'b111);
    bus.in_valid = 1; bus.data_in = 8'h11; bus.sel = 2'b00;
    #1 check("bp_stall", 32'(bus.in_ready), 0);
    tick();
    check("bp_hold", 32'(bus.data_a), 32'h FC);
    bus.ready_a = 1;
    #1 check("bp_release", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 0; bus.ready_a = 0;
    check("bp_data", 32'(bus.data_a), 32'h11);
    check("bp_valid", 32'(bus.valid_a), 1);
    bus.ready_b = 1;
    for (int k = 1; k <= 4; k++) begin
      bus.in_valid = 1; bus.data_in = 8'(k); bus.sel = 2'b01;
      #1 check("stream_ready", 32'(bus.in_ready), 1);
      tick();
      check("stream_data", 32'(bus.data_b), 32'(k));
    end
    bus.in_valid = 0;
    tick();
    bus.ready_b = 0;
    bus.in_valid = 1; bus.data_in = 8'hAA; bus.sel = 2'b11;
    #1 check("ill_ready", 32'(bus.in_ready), 1);
    tick();
    bus.in_valid = 0;
    check("ill_sel_err", 32'(bus.sel_err), 1);
    check("ill_count", 32'(bus.err_count), 1);
    check("ill_valid", 32'({bus.valid_a, bus.valid_b, bus.valid_c}), 32'b101);
    tick();
    check("ill_pulse_end", 32'(bus.sel_err), 0);
    bus.in_valid = 1; bus.sel = 2'b11;
    for (int k = 0; k < 260; k++) begin
      bus.data_in = 8'(k);
      tick();
      check("sat_pulse", 32'(bus.sel_err), 1);
    end
    bus.in_valid = 0;
    check("sat_count", 32'(bus.err_count), 255);
    held = 0;
    for (int k = 0; k < 400; k++) begin
      bus.ready_a = 1'($urandom_range(1)); bus.ready_b = 1'($urandom_range(1)); bus.ready_c = 1'($urandom_range(1));
      if (!held) begin
        bus.in_valid = 1'($urandom_range(1)); bus.sel = 2'($urandom_range(3)); bus.data_in = 8'($urandom);
      end
      #1 held = bus.in_valid & !bus.in_ready;
      tick();
    end
    bus.in_valid = 0; bus.ready_a = 0; bus.ready_b = 0; bus.ready_c = 0;
    send(8'h5A, 2'b00);
    send(8'hC3, 2'b10);
    check("mid_pre_valid", 32'({bus.valid_a, bus.valid_c}), 32'b11);
    bus.in_valid = 1; bus.data_in = 8'h77; bus.sel = 2'b01; rst = 1;
    tick();
    rst = 0; bus.in_valid = 0;
    check("mid_valid", 32'({bus.valid_a, bus.valid_b, bus.valid_c}), 0);
    check("mid_data_a", 32'(bus.data_a), 0);
    check("mid_data_b", 32'(bus.data_b), 0);
    check("mid_data_c", 32'(bus.data_c), 0);
    check("mid_count", 32'(bus.err_count), 0);
    tick();
    check("mid_no_capture", 32'(bus.valid_b), 0);
    repeat (2) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
